// File: rtl/rng_arb_pkg.sv
// Shared definitions for the rng_arbiter block: FSM state encoding and the
// random word width.
package rng_arb_pkg;

   localparam int RNG_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rng_arb_rr.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo N_REQ, and returns the first set index. Works for any N_REQ in
// 2..16, including non-powers of two.
module rng_arb_rr #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic                     found_o,
   output logic [$clog2(N_REQ)-1:0] idx_o
);

   localparam int PW = $clog2(N_REQ);

   logic [PW:0] pos;

   // Walk candidates from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         pos = {1'b0, ptr_i} + (PW+1)'(i);
         if (pos >= (PW+1)'(N_REQ)) begin
            pos = pos - (PW+1)'(N_REQ);
         end
         if (req_i[pos[PW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = pos[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one Mersenne Twister core among N_REQ
// requesters. One grant per generated word; after each grant the core is
// restarted and the arbiter waits for rng_valid to drop before it looks at
// requests again, so a stale word is never handed out twice.
// Optional watchdog: define RNG_ARB_WDOG_EN to enable the TIMEOUT counter
// and the sticky err output; otherwise err is tied low.
//
//   state    | meaning
//   ST_IDLE  | waiting for rng_valid and at least one request
//   ST_GRANT | one-cycle gnt + rng_start pulse, pointer advances
//   ST_DRAIN | waiting for the core to drop rng_valid while it refills
module rng_arbiter
   import rng_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [RNG_W-1:0] data_out,
   output logic             busy,
   output logic             rng_start,
   input  logic             rng_valid,
   input  logic [RNG_W-1:0] rng_data,
   output logic             err
);

   localparam int PW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
      $error("rng_arbiter: N_REQ must be 2..16 and TIMEOUT at least 1");
   end

   arb_state_e       state_q;
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    ptr_d;
   logic [PW-1:0]    win_q;
   logic [PW-1:0]    win_idx;
   logic             found;
   logic [N_REQ-1:0] gnt_q;
   logic [RNG_W-1:0] data_q;
   logic             start_q;
   logic             busy_q;
   logic             wd_fire;

   rng_arb_rr #(.N_REQ(N_REQ)) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .found_o (found),
      .idx_o   (win_idx)
   );

   // Pointer moves one past the winner, wrapping at N_REQ-1.
   assign ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef RNG_ARB_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q;
   logic [WD_W-1:0] wd_d;
   logic            wd_run;
   logic            err_q;

   // Count while stuck in DRAIN or while requests wait on an invalid core;
   // any state change (including the timeout itself) restarts the count.
   always_comb begin
      wd_run  = (state_q == ST_DRAIN) ||
                ((state_q == ST_IDLE) && (|req) && !rng_valid);
      wd_fire = wd_run && (wd_q == WD_W'(TIMEOUT - 1));
      wd_d    = (wd_run && !wd_fire && !((state_q == ST_DRAIN) && !rng_valid))
                ? wd_q + 1'b1 : '0;
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         if (wd_fire) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign wd_fire = 1'b0;
   assign err     = 1'b0;
`endif

   // Arbitration FSM with registered grant, start, busy and data outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         gnt_q   <= '0;
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rng_valid && found) begin
                  data_q  <= rng_data;
                  win_q   <= win_idx;
                  gnt_q   <= N_REQ'(1) << win_idx;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               ptr_q   <= ptr_d;
               state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!rng_valid || wd_fire) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign data_out  = data_q;
   assign rng_start = start_q;
   assign busy      = busy_q;

endmodule
